// File: rtl/rvfi_retire_buffer_if.sv
// Retirement capture / replay bundle for rvfi_retire_buffer.
// The slave modport is the buffer's view; master is the environment
// (the core's RVFI port plus the reference-model consumer).
interface rvfi_retire_buffer_if #(
  parameter int NRET = 2,
  parameter int XLEN = 32
);
  // Retirement side, channel 0 is the oldest instruction of the group
  logic [NRET-1:0]      rvfi_valid_i;
  logic [NRET*64-1:0]   rvfi_order_i;
  logic [NRET*XLEN-1:0] rvfi_pc_i;
  logic [NRET*32-1:0]   rvfi_insn_i;
  logic [NRET-1:0]      rvfi_trap_i;

  // Replay stream toward the reference model
  logic                 out_valid_o;
  logic                 out_ready_i;
  logic [63:0]          out_order_o;
  logic [XLEN-1:0]      out_pc_o;
  logic [31:0]          out_insn_o;
  logic                 out_trap_o;

  modport slave (
    input  rvfi_valid_i, rvfi_order_i, rvfi_pc_i, rvfi_insn_i, rvfi_trap_i,
    input  out_ready_i,
    output out_valid_o, out_order_o, out_pc_o, out_insn_o, out_trap_o
  );

  modport master (
    output rvfi_valid_i, rvfi_order_i, rvfi_pc_i, rvfi_insn_i, rvfi_trap_i,
    output out_ready_i,
    input  out_valid_o, out_order_o, out_pc_o, out_insn_o, out_trap_o
  );
endinterface

// File: rtl/rvfi_retire_buffer.sv
// rvfi_retire_buffer: captures up to NRET RVFI retirements per cycle,
// compacts them in program order into a DEPTH-entry circular queue and
// replays them one per cycle over a valid/ready stream. A group that does
// not fit is dropped whole and counted.
// Optional feature macro: RVFI_RETIRE_BUFFER_ORDER_CHECK_EN enables the
// rvfi_order continuity checker driving order_err_o.
module rvfi_retire_buffer #(
  parameter int NRET  = 2,
  parameter int DEPTH = 8,
  parameter int XLEN  = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  rvfi_retire_buffer_if.slave        bus,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       overflow_o,
  output logic [15:0]                drop_cnt_o,
  output logic                       order_err_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  // Payload storage; not reset, validity is carried by count_q alone
  logic [63:0]     mem_order [DEPTH];
  logic [XLEN-1:0] mem_pc    [DEPTH];
  logic [31:0]     mem_insn  [DEPTH];
  logic            mem_trap  [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   drop_cnt_q, drop_cnt_d;

  logic [CW-1:0] n_push;
  logic [CW:0]   free_slots;
  logic          head_valid;
  logic          pop;
  logic          accept;
  logic          drop;
  logic [PW-1:0] slot_acc;
  logic [PW-1:0] wr_slot [NRET];
  logic [63:0]   head_order;

  function automatic logic [CW-1:0] popcount(input logic [NRET-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int k = 0; k < NRET; k++) begin
      c = c + CW'(v[k]);
    end
    return c;
  endfunction

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [CW-1:0] b);
    logic [16:0] s;
    s = {1'b0, a} + 17'(b);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  assign head_valid = (count_q != '0);
  assign pop        = head_valid & bus.out_ready_i;
  assign n_push     = popcount(bus.rvfi_valid_i);
  // A same-cycle pop releases its slot to the incoming group
  assign free_slots = DEPTH_C - {1'b0, count_q} + (CW + 1)'(pop);
  assign accept     = ({1'b0, n_push} <= free_slots);
  assign drop       = ~accept;

  // Compact valid channels: each valid channel lands after the earlier valid ones
  always_comb begin
    slot_acc = '0;
    for (int k = 0; k < NRET; k++) begin
      wr_slot[k] = wr_ptr_q + slot_acc;
      if (bus.rvfi_valid_i[k]) begin
        slot_acc = slot_acc + PW'(1);
      end
    end
  end

  // Next-state for pointers, occupancy and drop bookkeeping
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (accept) begin
      wr_ptr_d = wr_ptr_q + PW'(n_push);
      count_d  = count_q + n_push - CW'(pop);
    end else begin
      count_d    = count_q - CW'(pop);
      overflow_d = 1'b1;
      drop_cnt_d = sat_add16(drop_cnt_q, n_push);
    end
  end

  // Control state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Write every valid channel of an accepted group into its compacted slot
  always_ff @(posedge clk_i) begin
    if (accept) begin
      for (int k = 0; k < NRET; k++) begin
        if (bus.rvfi_valid_i[k]) begin
          mem_order[wr_slot[k]] <= bus.rvfi_order_i[64*k +: 64];
          mem_pc[wr_slot[k]]    <= bus.rvfi_pc_i[XLEN*k +: XLEN];
          mem_insn[wr_slot[k]]  <= bus.rvfi_insn_i[32*k +: 32];
          mem_trap[wr_slot[k]]  <= bus.rvfi_trap_i[k];
        end
      end
    end
  end

  // Head payload is forced to zero when empty so stale slots never leak out
  assign head_order      = head_valid ? mem_order[rd_ptr_q] : '0;
  assign bus.out_valid_o = head_valid;
  assign bus.out_order_o = head_order;
  assign bus.out_pc_o    = head_valid ? mem_pc[rd_ptr_q] : '0;
  assign bus.out_insn_o  = head_valid ? mem_insn[rd_ptr_q] : '0;
  assign bus.out_trap_o  = head_valid & mem_trap[rd_ptr_q];

  assign count_o    = count_q;
  assign overflow_o = overflow_q;
  assign drop_cnt_o = drop_cnt_q;

`ifdef RVFI_RETIRE_BUFFER_ORDER_CHECK_EN
  logic [63:0] last_order_q;
  logic        seen_q, seen_d;
  logic        order_err_q, order_err_d;

  // Flag any pop whose order is not exactly one past the previous pop
  always_comb begin
    seen_d      = seen_q;
    order_err_d = order_err_q;
    if (pop) begin
      seen_d = 1'b1;
      if (seen_q && (head_order != last_order_q + 64'd1)) begin
        order_err_d = 1'b1;
      end
    end
  end

  // Checker control state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      seen_q      <= 1'b0;
      order_err_q <= 1'b0;
    end else begin
      seen_q      <= seen_d;
      order_err_q <= order_err_d;
    end
  end

  // Remember the order of the entry just popped
  always_ff @(posedge clk_i) begin
    if (pop) begin
      last_order_q <= head_order;
    end
  end

  assign order_err_o = order_err_q;
`else
  assign order_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_rvfi_retire_buffer.sv
// Scoreboard bench for rvfi_retire_buffer (NRET=2, DEPTH=8, XLEN=32).
// The driver keeps a queue-based reference model and pushes every entry the
// model pops into exp_q; an independent negedge monitor compares the DUT.
module tb_rvfi_retire_buffer;
  localparam int NRET  = 2;
  localparam int DEPTH = 8;
  localparam int XLEN  = 32;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk_i  = 1'b0;
  logic          rst_ni = 1'b1;
  logic [CW-1:0] count_o;
  logic          overflow_o;
  logic [15:0]   drop_cnt_o;
  logic          order_err_o;

  rvfi_retire_buffer_if #(.NRET(NRET), .XLEN(XLEN)) bus ();

  rvfi_retire_buffer #(.NRET(NRET), .DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .bus         (bus),
    .count_o     (count_o),
    .overflow_o  (overflow_o),
    .drop_cnt_o  (drop_cnt_o),
    .order_err_o (order_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [63:0]     order;
    logic [XLEN-1:0] pc;
    logic [31:0]     insn;
    logic            trap;
  } ent_t;

  ent_t mdl_q[$];
  ent_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // model state (next-cycle view) and the published current-cycle view
  logic        ovf_m = 1'b0;
  int          drop_m = 0;
  logic        err_m = 1'b0;
  logic        seen_m = 1'b0;
  logic [63:0] last_m = '0;
  int          cur_cnt = 0;
  logic        cur_ovf = 1'b0;
  int          cur_drop = 0;
  logic        cur_err = 1'b0;
  logic        mon_en = 1'b0;
  logic [63:0] next_order = '0;
  ent_t        mon_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    bus.rvfi_valid_i = '0;
    bus.rvfi_order_i = '0;
    bus.rvfi_pc_i    = '0;
    bus.rvfi_insn_i  = '0;
    bus.rvfi_trap_i  = '0;
    bus.out_ready_i  = 1'b0;
  endtask

  task automatic model_reset();
    mdl_q.delete();
    exp_q.delete();
    ovf_m = 1'b0; drop_m = 0; err_m = 1'b0; seen_m = 1'b0; last_m = '0;
    cur_cnt = 0; cur_ovf = 1'b0; cur_drop = 0; cur_err = 1'b0;
  endtask

  // Asynchronous reset: outputs must be zero without waiting for a clock
  task automatic do_reset(input string tag);
    rst_ni = 1'b0;
    #1;
    chk({tag, "_count"},  64'(count_o), 64'd0);
    chk({tag, "_valid"},  64'(bus.out_valid_o), 64'd0);
    chk({tag, "_order"},  bus.out_order_o, 64'd0);
    chk({tag, "_pc"},     64'(bus.out_pc_o), 64'd0);
    chk({tag, "_insn"},   64'(bus.out_insn_o), 64'd0);
    chk({tag, "_trap"},   64'(bus.out_trap_o), 64'd0);
    chk({tag, "_ovf"},    64'(overflow_o), 64'd0);
    chk({tag, "_drop"},   64'(drop_cnt_o), 64'd0);
    chk({tag, "_ordErr"}, 64'(order_err_o), 64'd0);
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    #2 rst_ni = 1'b1;
  endtask

  // One clock cycle of stimulus plus the reference model's view of it
  task automatic step(input logic [NRET-1:0] v, input logic rdy,
                      input logic [63:0] o0, input logic [63:0] o1);
    ent_t e [NRET];
    ent_t p;
    int   n;
    int   free;
    @(posedge clk_i);
    #1;
    cur_cnt  = mdl_q.size();
    cur_ovf  = ovf_m;
    cur_drop = drop_m;
    cur_err  = err_m;
    for (int k = 0; k < NRET; k++) begin
      e[k].order = (k == 0) ? o0 : o1;
      e[k].pc    = XLEN'($urandom);
      e[k].insn  = $urandom;
      e[k].trap  = 1'($urandom_range(0, 1));
      bus.rvfi_order_i[64*k +: 64]     = e[k].order;
      bus.rvfi_pc_i[XLEN*k +: XLEN]    = e[k].pc;
      bus.rvfi_insn_i[32*k +: 32]      = e[k].insn;
      bus.rvfi_trap_i[k]               = e[k].trap;
    end
    bus.rvfi_valid_i = v;
    bus.out_ready_i  = rdy;
    if (mdl_q.size() != 0 && rdy) begin
      p = mdl_q.pop_front();
      exp_q.push_back(p);
`ifdef RVFI_RETIRE_BUFFER_ORDER_CHECK_EN
      if (seen_m && p.order != last_m + 64'd1) err_m = 1'b1;
      seen_m = 1'b1;
      last_m = p.order;
`endif
    end
    free = DEPTH - mdl_q.size();
    n = $countones(v);
    if (n > free) begin
      ovf_m  = 1'b1;
      drop_m = (drop_m + n > 65535) ? 65535 : drop_m + n;
    end else begin
      for (int k = 0; k < NRET; k++) if (v[k]) mdl_q.push_back(e[k]);
    end
  endtask

  // Monitor: status every cycle, payload on every handshake
  always @(negedge clk_i) begin
    if (mon_en && rst_ni) begin
      chk("count",    64'(count_o), 64'(cur_cnt));
      chk("valid",    64'(bus.out_valid_o), 64'(cur_cnt != 0));
      chk("overflow", 64'(overflow_o), 64'(cur_ovf));
      chk("drop_cnt", 64'(drop_cnt_o), 64'(cur_drop));
      chk("order_err", 64'(order_err_o), 64'(cur_err));
      if (bus.out_valid_o && bus.out_ready_i) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pop", 64'(bus.out_valid_o & bus.out_ready_i), 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("out_order", bus.out_order_o, mon_e.order);
          chk("out_pc",    64'(bus.out_pc_o), 64'(mon_e.pc));
          chk("out_insn",  64'(bus.out_insn_o), 64'(mon_e.insn));
          chk("out_trap",  64'(bus.out_trap_o), 64'(mon_e.trap));
        end
      end
    end
  end

  initial begin
    logic [NRET-1:0] rv;
    logic            rr;
    logic [63:0]     a0, a1;
    int              rpct;

    idle_inputs();
    #2;
    do_reset("rst0");
    mon_en = 1'b1;

    // Two-wide group, then drain one per cycle
    step(2'b11, 1'b1, 64'd0, 64'd1);
    step(2'b00, 1'b1, 64'd0, 64'd0);
    chk("t1_cnt2", 64'(count_o), 64'd2);
    chk("t1_head0", bus.out_order_o, 64'd0);
    step(2'b00, 1'b1, 64'd0, 64'd0);
    chk("t1_cnt1", 64'(count_o), 64'd1);
    chk("t1_head1", bus.out_order_o, 64'd1);
    step(2'b00, 1'b1, 64'd0, 64'd0);
    chk("t1_cnt0", 64'(count_o), 64'd0);

    // Channel 1 only: compacted into the first slot
    do_reset("rst1");
    step(2'b10, 1'b0, 64'd99, 64'd5);
    step(2'b00, 1'b0, 64'd0, 64'd0);
    chk("t2_cnt", 64'(count_o), 64'd1);
    chk("t2_head", bus.out_order_o, 64'd5);

    // Fill, drop a whole group, push into a full queue alongside a pop, wrap
    do_reset("rst2");
    for (int g = 0; g < 4; g++) step(2'b11, 1'b0, 64'(2*g), 64'(2*g+1));
    step(2'b11, 1'b0, 64'd8, 64'd9);
    step(2'b00, 1'b0, 64'd0, 64'd0);
    chk("t3_cnt", 64'(count_o), 64'd8);
    chk("t3_ovf", 64'(overflow_o), 64'd1);
    chk("t3_drop", 64'(drop_cnt_o), 64'd2);
    chk("t3_head", bus.out_order_o, 64'd0);
    step(2'b01, 1'b1, 64'd8, 64'd0);
    step(2'b00, 1'b0, 64'd0, 64'd0);
    chk("t4_cnt", 64'(count_o), 64'd8);
    chk("t4_head", bus.out_order_o, 64'd1);
    chk("t4_drop", 64'(drop_cnt_o), 64'd2);
    for (int i = 0; i < 6; i++) step(2'b00, 1'b1, 64'd0, 64'd0);
    step(2'b11, 1'b0, 64'd9, 64'd10);
    step(2'b11, 1'b0, 64'd11, 64'd12);
    step(2'b00, 1'b0, 64'd0, 64'd0);
    chk("t5_cnt", 64'(count_o), 64'd6);
    chk("t5_head", bus.out_order_o, 64'd7);
    for (int i = 0; i < 7; i++) step(2'b00, 1'b1, 64'd0, 64'd0);
    chk("t5_empty", 64'(count_o), 64'd0);

    // Order gap 3 -> 5
    do_reset("rst3");
    step(2'b01, 1'b0, 64'd3, 64'd0);
    step(2'b01, 1'b0, 64'd5, 64'd0);
    step(2'b00, 1'b1, 64'd0, 64'd0);
    step(2'b00, 1'b1, 64'd0, 64'd0);
    step(2'b00, 1'b0, 64'd0, 64'd0);
`ifdef RVFI_RETIRE_BUFFER_ORDER_CHECK_EN
    chk("t6_order_err", 64'(order_err_o), 64'd1);
`else
    chk("t6_order_err", 64'(order_err_o), 64'd0);
`endif

    // Reset in the middle of traffic with five entries held
    do_reset("rst4");
    step(2'b11, 1'b0, 64'd0, 64'd1);
    step(2'b11, 1'b0, 64'd2, 64'd3);
    step(2'b01, 1'b0, 64'd4, 64'd0);
    step(2'b00, 1'b0, 64'd0, 64'd0);
    chk("t7_cnt5", 64'(count_o), 64'd5);
    #2;
    do_reset("mid");
    step(2'b01, 1'b0, 64'd40, 64'd0);
    step(2'b00, 1'b1, 64'd0, 64'd0);
    chk("t7_cnt1", 64'(count_o), 64'd1);
    chk("t7_head", bus.out_order_o, 64'd40);
    step(2'b00, 1'b0, 64'd0, 64'd0);

    // Randomised traffic with alternating fill and drain phases
    do_reset("rst5");
    next_order = '0;
    for (int i = 0; i < 3000; i++) begin
      rpct = ((i / 150) % 2 == 0) ? 3 : 8;
      rv = NRET'($urandom);
      rr = ($urandom_range(0, 9) < rpct);
      a0 = next_order;
      a1 = next_order + 64'(rv[0]);
      next_order = next_order + 64'($countones(rv));
      step(rv, rr, a0, a1);
    end
    for (int i = 0; i < DEPTH + 2; i++) step(2'b00, 1'b1, 64'd0, 64'd0);
    chk("final_empty", 64'(count_o), 64'd0);
    chk("final_sb_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
